avalon_burst_agent: RTL and testbench

// Avalon-MM burst-capable agent (responder) backed by on-chip word memory. It stands in
// for the SDRAM controller on the pixel-fetch path, serving the constant-burst read

---
 rtl/avalon_burst_agent.sv | 150 +++++++++++++++
 tb/tb_avalon_burst_agent.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_agent.sv
// Avalon-MM burst responder over on-chip word memory: burst writes with byte lanes,
// fixed-latency burst reads, optional pseudo-random waitrequest stalls in IDLE/WR_BURST.
module avalon_burst_agent #(
   parameter int unsigned MEM_WORDS    = 1024,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned MAX_BURST    = 16,
   parameter bit          STALL_EN     = 1'b0,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   localparam int unsigned BCW         = $clog2(MAX_BURST) + 1,
   localparam int unsigned IW          = $clog2(MEM_WORDS),
   localparam int unsigned LW          = $clog2(READ_LATENCY + 1)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [31:0]    address,
   input  logic           read,
   input  logic           write,
   input  logic [BCW-1:0] burstcount,
   input  logic [31:0]    writedata,
   input  logic [3:0]     byteenable,
   output logic [31:0]    readdata,
   output logic           readdatavalid,
   output logic           waitrequest,
   output logic           err_burst
);

   typedef enum logic [1:0] {StIdle, StWrBurst, StRdLat, StRdData} state_e;

   state_e         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [BCW-1:0] rem_q, rem_d;
   logic [LW-1:0]  lat_q, lat_d;
   logic           err_q, err_d;
   logic [15:0]    lfsr_q, lfsr_d;
   logic [31:0]    mem_q [MEM_WORDS];
   logic           mem_we;
   logic [IW-1:0]  mem_widx;
   logic [IW-1:0]  idx_in;
   logic [BCW-1:0] bc_eff;
   logic           bc_bad;
   logic           stall;
   logic           unused_addr;

   assign idx_in      = address[IW+1:2];
   assign unused_addr = ^{address[31:IW+2], address[1:0]};
   assign stall       = STALL_EN && lfsr_q[0] && lfsr_q[3];
   assign lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   assign err_burst   = err_q;

   always_comb begin
      bc_bad = (burstcount == '0) || (burstcount > BCW'(MAX_BURST));
      if (burstcount == '0) begin
         bc_eff = BCW'(1);
      end else if (burstcount > BCW'(MAX_BURST)) begin
         bc_eff = BCW'(MAX_BURST);
      end else begin
         bc_eff = burstcount;
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      rem_d         = rem_q;
      lat_d         = lat_q;
      err_d         = err_q;
      mem_we        = 1'b0;
      mem_widx      = idx_q;
      waitrequest   = 1'b1;
      readdatavalid = 1'b0;
      unique case (state_q)
         StIdle: begin
            waitrequest = stall;
            // read wins over a simultaneous write; the collision is flagged
            if (read && !stall) begin
               err_d = err_q | bc_bad | write;
               idx_d = idx_in;
               rem_d = bc_eff;
               if (READ_LATENCY > 1) begin
                  state_d = StRdLat;
                  lat_d   = LW'(READ_LATENCY - 2);
               end else begin
                  state_d = StRdData;
               end
            end else if (write && !stall) begin
               err_d    = err_q | bc_bad;
               mem_we   = 1'b1;
               mem_widx = idx_in;
               idx_d    = idx_in + IW'(1);
               rem_d    = bc_eff - BCW'(1);
               if (bc_eff != BCW'(1)) state_d = StWrBurst;
            end
         end
         StWrBurst: begin
            waitrequest = stall;
            if (write && !stall) begin
               mem_we = 1'b1;
               idx_d  = idx_q + IW'(1);
               rem_d  = rem_q - BCW'(1);
               if (rem_q == BCW'(1)) state_d = StIdle;
            end
         end
         StRdLat: begin
            if (lat_q == '0) state_d = StRdData;
            else lat_d = lat_q - LW'(1);
         end
         StRdData: begin
            readdatavalid = 1'b1;
            idx_d         = idx_q + IW'(1);
            rem_d         = rem_q - BCW'(1);
            if (rem_q == BCW'(1)) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // reset is asynchronous, so the handshake must close the instant it asserts
      if (!reset_n) begin
         waitrequest = 1'b1;
         mem_we      = 1'b0;
      end
   end

   assign readdata = readdatavalid ? mem_q[idx_q] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         rem_q   <= '0;
         lat_q   <= '0;
         err_q   <= 1'b0;
         lfsr_q  <= LFSR_SEED;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         lat_q   <= lat_d;
         err_q   <= err_d;
         lfsr_q  <= lfsr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) mem_q[mem_widx][8*b +: 8] <= writedata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_avalon_burst_agent.sv
// Bench for avalon_burst_agent: dut0 without stalls (latency 2), dut1 with stalls (latency 3),
// both checked every cycle against a transaction-level model plus literal readback checks.
module tb_avalon_burst_agent;
   localparam int W = 1024;

   logic        clk = 1'b0;
   logic        rst_n  [2];
   logic        rd_s   [2];
   logic        wr_s   [2];
   logic [31:0] addr_s [2];
   logic [4:0]  bc_s   [2];
   logic [31:0] wd_s   [2];
   logic [3:0]  be_s   [2];
   logic [31:0] rdata  [2];
   logic        rdv    [2];
   logic        wreq   [2];
   logic        err    [2];

   always #5 clk = ~clk;

   avalon_burst_agent #(.MEM_WORDS(1024), .READ_LATENCY(2), .MAX_BURST(16), .STALL_EN(1'b0),
                        .LFSR_SEED(16'hACE1)) u_dut0 (
      .clk(clk), .reset_n(rst_n[0]), .address(addr_s[0]), .read(rd_s[0]), .write(wr_s[0]),
      .burstcount(bc_s[0]), .writedata(wd_s[0]), .byteenable(be_s[0]), .readdata(rdata[0]),
      .readdatavalid(rdv[0]), .waitrequest(wreq[0]), .err_burst(err[0]));

   avalon_burst_agent #(.MEM_WORDS(1024), .READ_LATENCY(3), .MAX_BURST(16), .STALL_EN(1'b1),
                        .LFSR_SEED(16'hACE1)) u_dut1 (
      .clk(clk), .reset_n(rst_n[1]), .address(addr_s[1]), .read(rd_s[1]), .write(wr_s[1]),
      .burstcount(bc_s[1]), .writedata(wd_s[1]), .byteenable(be_s[1]), .readdata(rdata[1]),
      .readdatavalid(rdv[1]), .waitrequest(wreq[1]), .err_burst(err[1]));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int i, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s dut%0d t=%0t got=%h expected=%h", name, i, $time, got, exp);
      end
   endtask

   // Transaction-level model: memory image, one read burst window, write-burst pointer, LFSR.
   int          cyc = 0;
   int          lat_m  [2] = '{2, 3};
   bit          sten_m [2] = '{1'b0, 1'b1};
   logic [31:0] mem_m  [2][W];
   int          busy_hi[2] = '{-1, -1};
   int          rd_first[2], rd_n[2];
   logic [9:0]  rd_base[2], wr_idx[2];
   int          wr_rem [2];
   bit          err_m  [2];
   logic [15:0] lfsr_m [2];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      int e;
      e = cyc + 1;
      for (int i = 0; i < 2; i++) begin
         bit busy, st, acc;
         int n;
         logic [9:0] ix;
         busy = (cyc <= busy_hi[i]);
         st   = sten_m[i] && lfsr_m[i][0] && lfsr_m[i][3];
         acc  = rst_n[i] && (rd_s[i] || wr_s[i]) && !busy && !st;
         if (!rst_n[i]) begin
            busy_hi[i] = -1; rd_n[i] = 0; wr_rem[i] = 0; err_m[i] = 1'b0;
            lfsr_m[i] = 16'hACE1;
         end else begin
            lfsr_m[i] = {lfsr_m[i][0] ^ lfsr_m[i][2] ^ lfsr_m[i][3] ^ lfsr_m[i][5],
                         lfsr_m[i][15:1]};
            if (acc) begin
               if (wr_rem[i] > 0) begin
                  if (wr_s[i]) begin
                     mem_m[i][wr_idx[i]] = merge(mem_m[i][wr_idx[i]], wd_s[i], be_s[i]);
                     wr_idx[i] = wr_idx[i] + 10'd1;
                     wr_rem[i]--;
                  end
               end else begin
                  n  = (bc_s[i] == 0) ? 1 : (bc_s[i] > 16) ? 16 : int'(bc_s[i]);
                  ix = addr_s[i][11:2];
                  if (bc_s[i] == 0 || bc_s[i] > 16 || (rd_s[i] && wr_s[i])) err_m[i] = 1'b1;
                  if (rd_s[i]) begin
                     rd_first[i] = e + lat_m[i] - 1;
                     rd_n[i]     = n;
                     rd_base[i]  = ix;
                     busy_hi[i]  = e + lat_m[i] + n - 2;
                  end else begin
                     mem_m[i][ix] = merge(mem_m[i][ix], wd_s[i], be_s[i]);
                     wr_idx[i]    = ix + 10'd1;
                     wr_rem[i]    = n - 1;
                  end
               end
            end
         end
      end
      cyc = e;
   end

   logic [31:0] got0[$];
   int          first_cyc0;
   int          nbeats1 = 0;

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit ev, ew;
         logic [31:0] ed;
         logic [9:0] ix;
         ev = rst_n[i] && rd_n[i] > 0 && cyc >= rd_first[i] && cyc < rd_first[i] + rd_n[i];
         ew = !rst_n[i] || cyc <= busy_hi[i] || (sten_m[i] && lfsr_m[i][0] && lfsr_m[i][3]);
         ix = 10'(int'(rd_base[i]) + cyc - rd_first[i]);
         ed = ev ? mem_m[i][ix] : 32'd0;
         chk("waitrequest", i, 32'(wreq[i]), 32'(ew));
         chk("readdatavalid", i, 32'(rdv[i]), 32'(ev));
         chk("readdata", i, rdata[i], ed);
         chk("err_burst", i, 32'(err[i]), 32'(rst_n[i] && err_m[i]));
      end
      if (rdv[0] === 1'b1) begin
         if (got0.size() == 0) first_cyc0 = cyc;
         got0.push_back(rdata[0]);
      end
      if (rdv[1] === 1'b1) nbeats1++;
   end

   task automatic drive(input int i, input bit r, input bit w, input logic [31:0] a,
                        input logic [4:0] bc, input logic [31:0] d, input logic [3:0] be);
      bit acc = 1'b0;
      int t = 0;
      rd_s[i] = r; wr_s[i] = w; addr_s[i] = a; bc_s[i] = bc; wd_s[i] = d; be_s[i] = be;
      while (!acc && t < 100) begin
         @(negedge clk);
         acc = (wreq[i] === 1'b0);
         @(posedge clk);
         #1;
         t++;
      end
      rd_s[i] = 1'b0; wr_s[i] = 1'b0;
      chk("accept_timeout", i, 32'(acc), 32'd1);
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset(input int i);
      rst_n[i] = 1'b0;
      settle(2);
      rst_n[i] = 1'b1;
      #1;
   endtask

   initial begin
      int a_cyc;
      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0; rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = '0;
         bc_s[i] = '0; wd_s[i] = '0; be_s[i] = '0;
      end
      settle(3);
      // 1: reset values and release
      chk("t1_wait_in_reset", 0, 32'(wreq[0]), 32'd1);
      chk("t1_rdv_in_reset", 0, 32'(rdv[0]), 32'd0);
      chk("t1_rdata_in_reset", 0, rdata[0], 32'd0);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      #1;
      chk("t1_wait_released", 0, 32'(wreq[0]), 32'd0);
      settle(1);

      // 2: burst write 1..4 then burst read back
      drive(0, 1'b0, 1'b1, 32'h40, 5'd4, 32'd1, 4'hF);
      for (int k = 2; k <= 4; k++) drive(0, 1'b0, 1'b1, 32'h0, 5'd0, 32'(k), 4'hF);
      got0.delete();
      drive(0, 1'b1, 1'b0, 32'h40, 5'd4, 32'h0, 4'h0);
      a_cyc = cyc;
      settle(8);
      chk("t2_count", 0, 32'(got0.size()), 32'd4);
      for (int k = 0; k < 4 && k < got0.size(); k++) chk("t2_beat", 0, got0[k], 32'(k + 1));
      chk("t2_latency", 0, 32'(first_cyc0 + 1 - a_cyc), 32'd2);

      // 3: byte lanes
      drive(0, 1'b0, 1'b1, 32'h80, 5'd1, 32'h11223344, 4'hF);
      drive(0, 1'b0, 1'b1, 32'h80, 5'd1, 32'hAABBCCDD, 4'b0101);
      got0.delete();
      drive(0, 1'b1, 1'b0, 32'h80, 5'd1, 32'h0, 4'h0);
      settle(5);
      chk("t3_count", 0, 32'(got0.size()), 32'd1);
      if (got0.size() > 0) chk("t3_merge", 0, got0[0], 32'h11BB33DD);

      // 4: write burst wrapping past the top word
      drive(0, 1'b0, 1'b1, 32'(4 * (W - 2)), 5'd16, 32'd1, 4'hF);
      for (int k = 2; k <= 16; k++) drive(0, 1'b0, 1'b1, 32'h0, 5'd0, 32'(k), 4'hF);
      got0.delete();
      drive(0, 1'b1, 1'b0, 32'h0, 5'd14, 32'h0, 4'h0);
      settle(18);
      chk("t4_count", 0, 32'(got0.size()), 32'd14);
      for (int k = 0; k < 14 && k < got0.size(); k++) chk("t4_beat", 0, got0[k], 32'(k + 3));
      chk("t4_err", 0, 32'(err[0]), 32'd0);

      // 5: burstcount 0, read+write collision, oversize burst
      got0.delete();
      drive(0, 1'b1, 1'b0, 32'h40, 5'd0, 32'h0, 4'h0);
      settle(6);
      chk("t5_bc0_count", 0, 32'(got0.size()), 32'd1);
      if (got0.size() > 0) chk("t5_bc0_data", 0, got0[0], 32'd1);
      chk("t5_bc0_err", 0, 32'(err[0]), 32'd1);
      pulse_reset(0);
      chk("t5_err_cleared", 0, 32'(err[0]), 32'd0);
      got0.delete();
      drive(0, 1'b1, 1'b1, 32'h40, 5'd2, 32'hDEAD0000, 4'hF);
      settle(6);
      chk("t5_rw_count", 0, 32'(got0.size()), 32'd2);
      if (got0.size() > 1) chk("t5_rw_data", 0, got0[1], 32'd2);
      chk("t5_rw_err", 0, 32'(err[0]), 32'd1);
      pulse_reset(0);
      got0.delete();
      drive(0, 1'b1, 1'b0, 32'(4 * (W - 2)), 5'd17, 32'h0, 4'h0);
      settle(20);
      chk("t5_clamp_count", 0, 32'(got0.size()), 32'd16);
      if (got0.size() > 15) chk("t5_clamp_last", 0, got0[15], 32'd16);
      chk("t5_clamp_err", 0, 32'(err[0]), 32'd1);

      // 6: stalled host stream with a reset mid-read on dut1
      for (int b = 0; b < 4; b++) begin
         drive(1, 1'b0, 1'b1, 32'(64 * b), 5'd16, 32'hC0DE0000 + 32'(16 * b), 4'hF);
         for (int k = 1; k < 16; k++)
            drive(1, 1'b0, 1'b1, 32'h0, 5'd0, 32'hC0DE0000 + 32'(16 * b + k), 4'hF);
      end
      nbeats1 = 0;
      for (int r = 0; r < 100; r++) begin
         drive(1, 1'b1, 1'b0, 32'(4 * ((r * 4) % 48)), 5'd16, 32'h0, 4'h0);
         if (r == 50) begin
            settle(5);
            pulse_reset(1);
         end
      end
      settle(30);
      chk("t6_beat_total", 1, 32'(nbeats1), 32'd1587);
      chk("t6_err", 1, 32'(err[1]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
